// File: rtl/axi_atop_responder.sv
// Memory-side AXI5 atomic executor: one transaction in flight, read-modify-write on an SRAM port.
// Define ATOP_MINMAX_EN to execute SMAX/SMIN/UMAX/UMIN; otherwise those four ops return SLVERR.
module axi_atop_responder #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic [5:0]             aw_atop_i,

    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_last_i,

    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,

    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [IdWidth-1:0]     r_id_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_last_o,

    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam logic [5:0]  AtopSwap   = 6'b110000;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        W_WAIT,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [5:0]             atop_q, atop_d;
    logic [7:0]             len_q, len_d;
    logic [DataWidth-1:0]   w_data_q, w_data_d;
    logic [DataWidth-1:0]   old_q, old_d;
    logic [DataWidth-1:0]   new_q, new_d;
    logic [1:0]             resp_q, resp_d;
    logic                   b_valid_q, b_valid_d;
    logic                   r_valid_q, r_valid_d;
    logic                   aw_ready_q, w_ready_q;
    logic                   mem_req_q, mem_we_q;

    logic                   need_r;
    logic                   minmax_err;
    logic                   w_error;
    logic [DataWidth-1:0]   amo_result;

    // Loads and swaps owe the master an R beat, even when they fail.
    assign need_r = (atop_q[5:4] == 2'b10) || (atop_q == AtopSwap);

`ifdef ATOP_MINMAX_EN
    assign minmax_err = 1'b0;
`else
    assign minmax_err = (atop_q != 6'b0) && (atop_q != AtopSwap) && atop_q[2];
`endif

    assign w_error = (len_q != 8'd0)
                   || !w_last_i
                   || ((atop_q != 6'b0) && (w_strb_i != {StrbWidth{1'b1}}))
                   || ((atop_q[5:4] == 2'b11) && (atop_q != AtopSwap))
                   || minmax_err;

    always_comb begin
        amo_result = w_data_q;
        if (atop_q != AtopSwap) begin
            case (atop_q[2:0])
                3'd0: amo_result = mem_rdata_i + w_data_q;
                3'd1: amo_result = mem_rdata_i & ~w_data_q;
                3'd2: amo_result = mem_rdata_i ^ w_data_q;
                3'd3: amo_result = mem_rdata_i | w_data_q;
`ifdef ATOP_MINMAX_EN
                3'd4: amo_result = ($signed(mem_rdata_i) > $signed(w_data_q)) ? mem_rdata_i : w_data_q;
                3'd5: amo_result = ($signed(mem_rdata_i) < $signed(w_data_q)) ? mem_rdata_i : w_data_q;
                3'd6: amo_result = (mem_rdata_i > w_data_q) ? mem_rdata_i : w_data_q;
                3'd7: amo_result = (mem_rdata_i < w_data_q) ? mem_rdata_i : w_data_q;
`endif
                default: amo_result = w_data_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        atop_d    = atop_q;
        len_d     = len_q;
        w_data_d  = w_data_q;
        old_d     = old_q;
        new_d     = new_q;
        resp_d    = resp_q;
        b_valid_d = b_valid_q;
        r_valid_d = r_valid_q;

        unique case (state_q)
            IDLE: begin
                if (aw_valid_i && aw_ready_q) begin
                    id_d    = aw_id_i;
                    addr_d  = aw_addr_i;
                    atop_d  = aw_atop_i;
                    len_d   = aw_len_i;
                    old_d   = '0;
                    state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_valid_i && w_ready_q) begin
                    w_data_d = w_data_i;
                    if (w_error) begin
                        // old_q stays zero, so a failed load/swap returns zero data.
                        resp_d    = RespSlvErr;
                        b_valid_d = 1'b1;
                        r_valid_d = need_r;
                        state_d   = RESP;
                    end else begin
                        resp_d = RespOkay;
                        if (atop_q == 6'b0) begin
                            new_d   = w_data_i;
                            state_d = WR_REQ;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (mem_gnt_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    old_d   = mem_rdata_i;
                    new_d   = amo_result;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_gnt_i) begin
                    b_valid_d = 1'b1;
                    r_valid_d = need_r;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (b_ready_i) begin
                    b_valid_d = 1'b0;
                end
                if (r_ready_i) begin
                    r_valid_d = 1'b0;
                end
                if (!b_valid_d && !r_valid_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and request outputs are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            atop_q     <= '0;
            len_q      <= '0;
            w_data_q   <= '0;
            old_q      <= '0;
            new_q      <= '0;
            resp_q     <= RespOkay;
            b_valid_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            atop_q     <= atop_d;
            len_q      <= len_d;
            w_data_q   <= w_data_d;
            old_q      <= old_d;
            new_q      <= new_d;
            resp_q     <= resp_d;
            b_valid_q  <= b_valid_d;
            r_valid_q  <= r_valid_d;
            aw_ready_q <= (state_d == IDLE);
            w_ready_q  <= (state_d == W_WAIT);
            mem_req_q  <= (state_d == RD_REQ) || (state_d == WR_REQ);
            mem_we_q   <= (state_d == WR_REQ);
        end
    end

    assign aw_ready_o  = aw_ready_q;
    assign w_ready_o   = w_ready_q;
    assign b_valid_o   = b_valid_q;
    assign b_id_o      = id_q;
    assign b_resp_o    = resp_q;
    assign r_valid_o   = r_valid_q;
    assign r_id_o      = id_q;
    assign r_data_o    = old_q;
    assign r_resp_o    = resp_q;
    assign r_last_o    = r_valid_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = new_q;

endmodule

// File: tb/tb_axi_atop_responder.sv
// Scoreboard bench for axi_atop_responder: reference model predicts B/R/memory traffic at issue time,
// independent monitors compare at each handshake. Honours ATOP_MINMAX_EN like the design.
module tb_axi_atop_responder;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
    } b_exp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] data;
    } m_exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        aw_valid_i, aw_ready_o;
    logic [3:0]  aw_id_i;
    logic [31:0] aw_addr_i;
    logic [7:0]  aw_len_i;
    logic [5:0]  aw_atop_i;
    logic        w_valid_i, w_ready_o;
    logic [63:0] w_data_i;
    logic [7:0]  w_strb_i;
    logic        w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        r_valid_o, r_ready_i;
    logic [3:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    m_exp_t      m_q[$];
    logic [63:0] sram    [logic [31:0]];
    logic [63:0] ref_mem [logic [31:0]];
    logic [31:0] addr_tab [8];

    int n_cmp = 0;
    int n_err = 0;
    bit r_hold = 1'b0;
    bit mem_zero_wait = 1'b0;
    bit rd_granted = 1'b0;
    bit lat_run = 1'b0;
    int lat_cnt = 0;
    int last_lat = -1;

    axi_atop_responder #(
        .AddrWidth(32),
        .DataWidth(64),
        .IdWidth(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
        .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_atop_i(aw_atop_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference semantics of each atomic op, straight from the op table.
    function automatic logic [63:0] refOp(input logic [5:0] atop, input logic [63:0] o, input logic [63:0] w);
        longint so;
        longint sw;
        so = o;
        sw = w;
        if (atop == 6'b110000) return w;
        case (atop[2:0])
            3'd0: return o + w;
            3'd1: return o & ~w;
            3'd2: return o ^ w;
            3'd3: return o | w;
            3'd4: return (so > sw) ? o : w;
            3'd5: return (so < sw) ? o : w;
            3'd6: return (o > w) ? o : w;
            default: return (o < w) ? o : w;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [5:0] atop, input logic [63:0] data, input logic [7:0] strb,
                                 input logic last, input int wdelay);
        logic   err;
        logic   minmax_bad;
        logic [63:0] old;
        b_exp_t be;
        r_exp_t re;
        m_exp_t me;
        int     n;
        old = ref_mem[addr];
`ifdef ATOP_MINMAX_EN
        minmax_bad = 1'b0;
`else
        minmax_bad = (atop != 6'b0) && (atop != 6'b110000) && atop[2];
`endif
        err = (len != 0) || !last || ((atop != 6'b0) && (strb != 8'hFF))
            || ((atop[5:4] == 2'b11) && (atop != 6'b110000)) || minmax_bad;
        if (!err) begin
            if (atop != 6'b0) begin
                me.we = 1'b0; me.addr = addr; me.data = '0;
                m_q.push_back(me);
                ref_mem[addr] = refOp(atop, old, data);
            end else begin
                ref_mem[addr] = data;
            end
            me.we = 1'b1; me.addr = addr; me.data = ref_mem[addr];
            m_q.push_back(me);
        end
        be.id = id;
        be.resp = err ? 2'b10 : 2'b00;
        b_q.push_back(be);
        if ((atop[5:4] == 2'b10) || (atop == 6'b110000)) begin
            re.id = id;
            re.data = err ? 64'd0 : old;
            re.resp = err ? 2'b10 : 2'b00;
            r_q.push_back(re);
        end

        @(posedge clk); #1;
        aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_atop_i = atop;
        n = 0;
        @(negedge clk);
        while (!aw_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!aw_ready_o) checkOutput("aw_accept_timeout", aw_ready_o, 1);
        @(posedge clk); #1;
        aw_valid_i = 1'b0;
        repeat (wdelay) begin
            @(posedge clk); #1;
        end
        w_valid_i = 1'b1; w_data_i = data; w_strb_i = strb; w_last_i = last;
        n = 0;
        @(negedge clk);
        while (!w_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!w_ready_o) checkOutput("w_accept_timeout", w_ready_o, 1);
        @(posedge clk); #1;
        w_valid_i = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while ((b_q.size() != 0 || r_q.size() != 0 || m_q.size() != 0 || b_valid_o || r_valid_o || !aw_ready_o)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_outstanding", 64'(b_q.size() + r_q.size() + m_q.size()), 0);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [63:0] val);
        sram[addr] = val;
        ref_mem[addr] = val;
    endtask

    // Ready generator for B and R; R can be pinned low.
    initial begin
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            b_ready_i = ($urandom_range(0, 2) != 0);
            r_ready_i = r_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // SRAM model: random grant, read data one cycle after a granted read.
    initial begin : mem_model
        logic        rd_pend;
        logic [63:0] rd_val;
        m_exp_t      me;
        rd_pend = 1'b0;
        rd_val = '0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid_i = rd_pend;
            mem_rdata_i = rd_pend ? rd_val : {$urandom, $urandom};
            rd_pend = 1'b0;
            mem_gnt_i = mem_zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (!rst_i && mem_req_o && mem_gnt_i) begin
                checkOutput("mem_req_expected", (m_q.size() > 0), 1);
                if (m_q.size() > 0) begin
                    me = m_q.pop_front();
                    checkOutput("mem_we", mem_we_o, me.we);
                    checkOutput("mem_addr", mem_addr_o, me.addr);
                    if (me.we) checkOutput("mem_wdata", mem_wdata_o, me.data);
                end
                if (mem_we_o) begin
                    sram[mem_addr_o] = mem_wdata_o;
                end else begin
                    rd_pend = 1'b1;
                    rd_val = sram.exists(mem_addr_o) ? sram[mem_addr_o] : 64'd0;
                    rd_granted = 1'b1;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every B/R handshake and checks valid stability.
    initial begin : resp_mon
        b_exp_t be;
        r_exp_t re;
        bit     b_hold;
        bit     r_stall;
        b_hold = 1'b0;
        r_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                b_hold = 1'b0;
                r_stall = 1'b0;
            end else begin
                if (b_hold) checkOutput("b_valid_held", b_valid_o, 1);
                if (r_stall) checkOutput("r_valid_held", r_valid_o, 1);
                if (b_valid_o && b_ready_i) begin
                    checkOutput("b_expected", (b_q.size() > 0), 1);
                    if (b_q.size() > 0) begin
                        be = b_q.pop_front();
                        checkOutput("b_id", b_id_o, be.id);
                        checkOutput("b_resp", b_resp_o, be.resp);
                    end
                end
                if (r_valid_o && r_ready_i) begin
                    checkOutput("r_expected", (r_q.size() > 0), 1);
                    if (r_q.size() > 0) begin
                        re = r_q.pop_front();
                        checkOutput("r_id", r_id_o, re.id);
                        checkOutput("r_data", r_data_o, re.data);
                        checkOutput("r_resp", r_resp_o, re.resp);
                        checkOutput("r_last", r_last_o, 1);
                    end
                end
                b_hold = b_valid_o && !b_ready_i;
                r_stall = r_valid_o && !r_ready_i;
            end
        end
    end

    // Cycles from the AW handshake cycle to the first cycle with B valid.
    always @(negedge clk) begin
        if (lat_run) begin
            lat_cnt++;
            if (b_valid_o) begin
                lat_run = 1'b0;
                last_lat = lat_cnt;
            end
        end
        if (aw_valid_i && aw_ready_o) begin
            lat_run = 1'b1;
            lat_cnt = 0;
        end
    end

    initial begin
        logic [63:0] saved;
        int          n;
        int          blocked;
        rst_i = 1'b1;
        aw_valid_i = 1'b0; aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_atop_i = '0;
        w_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr_tab[i] = 32'h40 + 32'(8 * i);
            preload(addr_tab[i], {$urandom, $urandom});
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {b_valid_o, r_valid_o, mem_req_o, aw_ready_o, w_ready_o}, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        $display("[TB] directed: plain write");
        applyStimulus(4'h1, 32'h40, 8'd0, 6'b000000, 64'h1234, 8'hFF, 1'b1, 0);
        waitIdle();

        $display("[TB] directed: ATOMICLOAD ADD with zero-wait memory");
        preload(32'h48, 64'h5);
        mem_zero_wait = 1'b1;
        last_lat = -1;
        applyStimulus(4'h2, 32'h48, 8'd0, 6'b100000, 64'h3, 8'hFF, 1'b1, 0);
        waitIdle();
        checkOutput("aw_to_valid_latency", 64'(last_lat), 5);
        mem_zero_wait = 1'b0;

        $display("[TB] directed: SWAP");
        preload(32'h50, 64'hAA);
        applyStimulus(4'h3, 32'h50, 8'd0, 6'b110000, 64'h55, 8'hFF, 1'b1, 1);
        waitIdle();

        $display("[TB] directed: SWAP with R stalled");
        preload(32'h50, 64'hAA);
        r_hold = 1'b1;
        applyStimulus(4'h4, 32'h50, 8'd0, 6'b110000, 64'h55, 8'hFF, 1'b1, 0);
        n = 0;
        while (b_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("swap_b_done_during_stall", 64'(b_q.size()), 0);
        @(posedge clk); #1;
        aw_valid_i = 1'b1; aw_id_i = 4'h5; aw_addr_i = 32'h58; aw_len_i = 8'd0; aw_atop_i = 6'b0;
        blocked = 0;
        repeat (10) begin
            @(negedge clk);
            if (aw_ready_o) blocked++;
        end
        checkOutput("aw_accepted_during_r_stall", 64'(blocked), 0);
        checkOutput("r_valid_during_stall", r_valid_o, 1);
        @(posedge clk); #1;
        aw_valid_i = 1'b0;
        r_hold = 1'b0;
        waitIdle();

        $display("[TB] directed: ATOMICSTORE SMAX");
        preload(32'h58, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(4'h6, 32'h58, 8'd0, 6'b010100, 64'h1, 8'hFF, 1'b1, 0);
        waitIdle();

        $display("[TB] directed: ATOMICLOAD with len 1");
        applyStimulus(4'h7, 32'h60, 8'd1, 6'b100000, 64'h9, 8'hFF, 1'b1, 0);
        waitIdle();

        $display("[TB] directed: reset during RD_WAIT");
        saved = ref_mem[32'h68];
        rd_granted = 1'b0;
        applyStimulus(4'h8, 32'h68, 8'd0, 6'b100000, 64'h11, 8'hFF, 1'b1, 0);
        n = 0;
        while (!rd_granted && n < 500) begin
            @(negedge clk); #2;
            n++;
        end
        checkOutput("read_granted_before_reset", rd_granted, 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mid_outputs", {b_valid_o, r_valid_o, mem_req_o, aw_ready_o, w_ready_o}, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        b_q.delete();
        r_q.delete();
        m_q.delete();
        ref_mem[32'h68] = saved;
        applyStimulus(4'h9, 32'h68, 8'd0, 6'b000000, 64'hCAFE, 8'hFF, 1'b1, 0);
        waitIdle();

        $display("[TB] random transactions");
        for (int t = 0; t < 80; t++) begin
            logic [5:0]  atop;
            logic [2:0]  op3;
            logic [7:0]  len;
            logic [7:0]  strb;
            logic        last;
            logic [63:0] data;
            int          cls;
            int          inj;
            cls = $urandom_range(0, 3);
            op3 = 3'($urandom_range(0, 7));
            case (cls)
                0: atop = 6'b000000;
                1: atop = {3'b010, op3};
                2: atop = {3'b100, op3};
                default: atop = 6'b110000;
            endcase
            len = 8'd0;
            last = 1'b1;
            strb = 8'hFF;
            inj = $urandom_range(0, 9);
            if (inj == 0) len = 8'($urandom_range(1, 7));
            else if (inj == 1) last = 1'b0;
            else if (inj == 2 && atop != 6'b0) strb = 8'($urandom_range(0, 254));
            if ($urandom_range(0, 1) != 0) data = {$urandom, $urandom};
            else data = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) data = ~data;
            applyStimulus(4'($urandom_range(0, 15)), addr_tab[$urandom_range(0, 7)], len, atop, data,
                          strb, last, $urandom_range(0, 2));
        end
        waitIdle();

        for (int i = 0; i < 8; i++) begin
            checkOutput("mem_final_contents", sram[addr_tab[i]], ref_mem[addr_tab[i]]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
